run_monitor: RTL and testbench

- Synthesisable run-control and performance-monitor block that sits beside the riscvpipeline core.
- Detects the halt instruction (EBREAK) on the fetch/retire stream and counts run cycles, retired instructions and N_EVT generic events (stalls, flushes, mispredicts…).
- Enforces a watchdog timeout.
- Results are exposed through a registered select/read port for the bench or a debug bus, replacing ad-hoc bench-side cycle counting.

---
 rtl/run_monitor_pkg.sv | 20 ++
 rtl/run_monitor_sat_counter.sv | 24 ++
 rtl/run_monitor.sv | 104 ++++++++++
 tb/tb_run_monitor.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/run_monitor_pkg.sv
// run_monitor_pkg: shared state type, halt encoding and read-select map
// for the run-control / performance-monitor block.
package run_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HALTED  = 2'd2,
    TIMEOUT = 2'd3
  } run_state_t;

  // RV32 EBREAK, the default end-of-run marker
  localparam logic [31:0] EBREAK_INSTR = 32'h00100073;

  // rd_sel encodings; event counters follow from SEL_EVT_BASE upward
  localparam int SEL_CYCLES   = 0;
  localparam int SEL_RETIRED  = 1;
  localparam int SEL_EVT_BASE = 2;

endpackage

// File: rtl/run_monitor_sat_counter.sv
// sat_counter: W-bit up-counter with synchronous clear that sticks at
// all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  // count up on inc, hold at max, clear wins over inc
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     r_cnt <= '0;
    else if (clr)                   r_cnt <= '0;
    else if (inc && (r_cnt != '1))  r_cnt <= r_cnt + W'(1);
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/run_monitor.sv
// run_monitor: run-control FSM plus cycle / retired / event counters with
// a registered read port. Optional watchdog: RUN_MONITOR_WATCHDOG_EN.
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int          CNT_W       = 32,
  parameter int          N_EVT       = 4,
  parameter int          TIMEOUT_CYC = 5000,
  parameter logic [31:0] HALT_INSTR  = EBREAK_INSTR
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         clear,
  input  logic [31:0]                  instr,
  input  logic                         instr_valid,
  input  logic [N_EVT-1:0]             evt,
  input  logic [$clog2(N_EVT+2)-1:0]   rd_sel,
  output logic [CNT_W-1:0]             rd_data,
  output logic                         running,
  output logic                         halted,
  output logic                         timeout
);

  localparam int NCNT = N_EVT + 2;

  run_state_t                   r_state, w_state_nxt;
  logic                         w_run, w_halt, w_retire, w_wd_hit;
  logic [NCNT-1:0]              w_inc;
  logic [NCNT-1:0][CNT_W-1:0]   w_cnt;
  logic [CNT_W-1:0]             w_rd_mux, r_rd_data;

  assign w_run    = (r_state == RUN);
  assign w_halt   = w_run && instr_valid && (instr == HALT_INSTR);
  assign w_retire = w_run && instr_valid && (instr != HALT_INSTR);

`ifdef RUN_MONITOR_WATCHDOG_EN
  // cycles is about to step from TIMEOUT_CYC-1 to TIMEOUT_CYC on this edge
  assign w_wd_hit = w_run && (w_cnt[SEL_CYCLES] == CNT_W'(TIMEOUT_CYC - 1));
`else
  // no watchdog in this build; the limit parameter has no consumer
  logic w_unused_to;
  assign w_unused_to = ^TIMEOUT_CYC;
  assign w_wd_hit    = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // next state: clear > halt > timeout > start
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start) w_state_nxt = RUN;
        RUN: begin
          if (w_halt)        w_state_nxt = HALTED;
          else if (w_wd_hit) w_state_nxt = TIMEOUT;
        end
        default: ;
      endcase
    end
  end

  // counter order matches the read-select map: cycles, retired, events
  assign w_inc = {evt & {N_EVT{w_run}}, w_retire, w_run};

  for (genvar g = 0; g < NCNT; g++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (clear),
      .inc   (w_inc[g]),
      .cnt   (w_cnt[g])
    );
  end

  // read mux; unmapped selects read as zero
  always_comb begin
    w_rd_mux = '0;
    if (int'(rd_sel) < NCNT) w_rd_mux = w_cnt[rd_sel];
  end

  // registered read port: pre-edge counter values, one cycle latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rd_data <= '0;
    else        r_rd_data <= w_rd_mux;
  end

  assign rd_data = r_rd_data;
  assign running = w_run;
  assign halted  = (r_state == HALTED);
`ifdef RUN_MONITOR_WATCHDOG_EN
  assign timeout = (r_state == TIMEOUT);
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: table-driven directed vectors, hand sequences for the
// multi-cycle corners, and random stimulus against a behavioural model.
module tb_run_monitor;

`ifdef RUN_MONITOR_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  localparam logic [31:0] HALT = 32'h00100073;
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam int          TO   = 20;
  localparam longint      MAXV = 64'h0000_0000_FFFF_FFFF;

  logic        clk = 1'b0, reset = 1'b0;
  logic        start = 0, clear = 0, instr_valid = 0;
  logic [31:0] instr = '0;
  logic [3:0]  evt = '0;
  logic [2:0]  rd_sel = 3'd7;
  logic [31:0] rd_data;
  logic        running, halted, timeout;

  logic        s_start = 0, s_clear = 0, s_valid = 0;
  logic [31:0] s_instr = '0;
  logic [3:0]  s_evt = '0;
  logic [2:0]  s_sel = 3'd7;
  logic [3:0]  s_rd;
  logic        s_running, s_halted, s_timeout;

  always #5 clk = ~clk;

  run_monitor #(.CNT_W(32), .N_EVT(4), .TIMEOUT_CYC(TO)) u_dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .instr(instr),
    .instr_valid(instr_valid), .evt(evt), .rd_sel(rd_sel), .rd_data(rd_data),
    .running(running), .halted(halted), .timeout(timeout));

  run_monitor #(.CNT_W(4), .N_EVT(4), .TIMEOUT_CYC(15)) u_sat (
    .clk(clk), .reset(reset), .start(s_start), .clear(s_clear), .instr(s_instr),
    .instr_valid(s_valid), .evt(s_evt), .rd_sel(s_sel), .rd_data(s_rd),
    .running(s_running), .halted(s_halted), .timeout(s_timeout));

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- behavioural model: run mode plus one count per read select ----
  typedef enum {M_IDLE, M_RUN, M_HALT, M_TO} mmode_t;
  mmode_t      m_mode;
  longint      m_cnt [6];
  logic [31:0] m_rd;

  task automatic model_reset();
    m_mode = M_IDLE;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_rd = '0;
  endtask

  function automatic longint bump(input longint v);
    return (v < MAXV) ? v + 1 : v;
  endfunction

  task automatic model_edge(input bit st, input bit cl, input logic [31:0] ins,
                            input bit v, input logic [3:0] e, input int sel);
    bit is_halt;
    m_rd = (sel < 6) ? m_cnt[sel][31:0] : 32'd0;
    if (cl) begin
      m_mode = M_IDLE;
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else if (m_mode == M_RUN) begin
      is_halt  = v && (ins == HALT);
      m_cnt[0] = bump(m_cnt[0]);
      if (v && !is_halt) m_cnt[1] = bump(m_cnt[1]);
      for (int i = 0; i < 4; i++) if (e[i]) m_cnt[2+i] = bump(m_cnt[2+i]);
      if (is_halt)                  m_mode = M_HALT;
      else if (WD && m_cnt[0] == TO) m_mode = M_TO;
    end else if (m_mode == M_IDLE && st) begin
      m_mode = M_RUN;
    end
  endtask

  // one clock: drive, edge, update model, sample 1 time unit later
  task automatic step(input bit st, input bit cl, input logic [31:0] ins,
                      input bit v, input logic [3:0] e, input logic [2:0] sel);
    start = st; clear = cl; instr = ins; instr_valid = v; evt = e; rd_sel = sel;
    @(posedge clk);
    model_edge(st, cl, ins, v, e, int'(sel));
    #1;
    chk("model_step", {29'd0, running, halted, timeout, rd_data},
        {29'd0, m_mode == M_RUN, m_mode == M_HALT, m_mode == M_TO, m_rd});
    start = 0; clear = 0;
  endtask

  task automatic idle(input logic [2:0] sel);
    step(0, 0, NOP, 0, 4'd0, sel);
  endtask

  typedef struct {
    bit st; bit cl; logic [31:0] ins; bit v; logic [2:0] sel;
    bit x_run; bit x_halt; logic [31:0] x_rd;
  } vec_t;
  vec_t tbl [16];

  function automatic vec_t mk(bit st, bit cl, logic [31:0] ins, bit v, logic [2:0] sel,
                              bit xr, bit xh, logic [31:0] xd);
    vec_t t;
    t.st = st; t.cl = cl; t.ins = ins; t.v = v; t.sel = sel;
    t.x_run = xr; t.x_halt = xh; t.x_rd = xd;
    return t;
  endfunction

  initial begin
    model_reset();
    // basic run: start, 10 instrs, halt, then read back cycles/retired
    tbl[0] = mk(0, 0, NOP, 0, 7, 0, 0, 0);
    tbl[1] = mk(1, 0, NOP, 0, 7, 1, 0, 0);
    for (int i = 2; i < 12; i++) tbl[i] = mk(0, 0, NOP, 1, 7, 1, 0, 0);
    tbl[12] = mk(0, 0, HALT, 1, 7, 0, 1, 0);
    tbl[13] = mk(0, 0, NOP, 0, 0, 0, 1, 11);
    tbl[14] = mk(0, 0, NOP, 0, 1, 0, 1, 10);
    tbl[15] = mk(0, 0, NOP, 0, 2, 0, 1, 0);

    #3;
    chk("reset_outputs", {running, halted, timeout, rd_data}, 35'd0);
    chk("reset_sat_outputs", {s_running, s_halted, s_timeout, s_rd}, 7'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      step(tbl[i].st, tbl[i].cl, tbl[i].ins, tbl[i].v, 4'd0, tbl[i].sel);
      chk($sformatf("tbl%0d_status", i), {running, halted, timeout},
          {tbl[i].x_run, tbl[i].x_halt, 1'b0});
      chk($sformatf("tbl%0d_rd", i), rd_data, tbl[i].x_rd);
    end

    // watchdog: no halt, timeout exactly 20 edges after start
    step(0, 1, NOP, 0, 0, 7);
    step(1, 0, NOP, 0, 0, 7);
    for (int k = 1; k <= 30; k++) begin
      idle(7);
      if (k == 19) chk("to_not_yet", {running, timeout}, 2'b10);
      if (k == 20) chk("to_flag", {running, timeout}, {!WD, WD});
    end
    idle(0);
    chk("to_cycles", rd_data, WD ? 32'd20 : 32'd30);

    // halt lands on the very edge the watchdog would fire
    step(0, 1, NOP, 0, 0, 7);
    step(1, 0, NOP, 0, 0, 7);
    repeat (19) idle(7);
    step(0, 0, HALT, 1, 0, 7);
    chk("halt_beats_to", {halted, timeout}, 2'b10);
    idle(0);
    chk("halt_to_cycles", rd_data, 32'd20);

    // events: 7 x 0101 then 3 x 1111
    step(0, 1, NOP, 0, 0, 7);
    step(1, 0, NOP, 0, 0, 7);
    repeat (7) step(0, 0, NOP, 0, 4'b0101, 7);
    repeat (3) step(0, 0, NOP, 0, 4'b1111, 7);
    step(0, 0, HALT, 1, 0, 7);
    idle(2); chk("evt0", rd_data, 32'd10);
    idle(3); chk("evt1", rd_data, 32'd3);
    idle(4); chk("evt2", rd_data, 32'd10);
    idle(5); chk("evt3", rd_data, 32'd3);
    idle(6); chk("sel6_zero", rd_data, 32'd0);
    idle(7); chk("sel7_zero", rd_data, 32'd0);

    // start while HALTED is ignored
    step(1, 0, NOP, 0, 0, 0);
    chk("start_in_halted", {running, halted}, 2'b01);
    idle(0);
    chk("halted_cycles_hold", rd_data, 32'd11);

    // start and clear together
    step(0, 1, NOP, 0, 0, 7);
    step(1, 0, NOP, 0, 0, 7);
    repeat (5) step(0, 0, NOP, 1, 0, 7);
    step(1, 1, NOP, 0, 0, 0);
    chk("start_clear_state", {running, halted, timeout}, 3'b000);
    idle(0); chk("start_clear_cycles", rd_data, 32'd0);
    idle(1); chk("start_clear_retired", rd_data, 32'd0);

    // 4-bit counters saturate (second instance, main DUT kept idle)
    s_start = 1; idle(7); s_start = 0;
    s_instr = NOP; s_valid = 1;
    repeat (20) idle(7);
    s_instr = HALT; idle(7); s_valid = 0;
    s_sel = 0; idle(7); chk("sat_cycles", s_rd, 4'd15);
    s_sel = 1; idle(7); chk("sat_retired", s_rd, 4'd15);
    chk("sat_status", {s_running, s_halted, s_timeout}, {1'b0, !WD, WD});

    // asynchronous reset mid-run
    step(0, 1, NOP, 0, 0, 7);
    step(1, 0, NOP, 0, 0, 7);
    repeat (8) step(0, 0, NOP, 1, 4'b0011, 0);
    chk("pre_areset_rd", rd_data, 32'd7);
    reset = 1'b0;
    #1;
    chk("areset_status", {running, halted, timeout}, 3'b000);
    chk("areset_rd", rd_data, 32'd0);
    model_reset();
    reset = 1'b1;
    for (int s = 0; s < 6; s++) idle(3'(s));
    chk("areset_evt3", rd_data, 32'd0);

    // random stimulus against the model
    step(0, 1, NOP, 0, 0, 7);
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0,
           ($urandom_range(0, 19) == 0) ? HALT : $urandom,
           1'($urandom_range(0, 1)), 4'($urandom), 3'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
